// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch constants, FSM state enum and buffer entry type.
package legv8_pkg;

    localparam int ADDR_W      = 16;
    localparam int INST_W      = 32;
    localparam int FETCH_DEPTH = 2;

    // BR XZR: used as the end-of-program marker.
    localparam logic [INST_W-1:0] HALT_INST = 32'hD600_03E0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order {pc, instruction} buffer. Slot 0 is always the head, so the head
// outputs come straight from registers.
module fetch_fifo
    import legv8_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [INST_W-1:0] head_inst_o
);

    localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

    fetch_entry_t      slot_q [FETCH_DEPTH];
    fetch_entry_t      slot_d [FETCH_DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  base;
    logic              pop_eff;
    logic              push_eff;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CNT_W'(FETCH_DEPTH));
    assign head_pc_o   = slot_q[0].pc;
    assign head_inst_o = slot_q[0].inst;

    // A pop shifts everything toward slot 0; a push then lands in the first free slot.
    always_comb begin
        slot_d   = slot_q;
        count_d  = count_q;
        pop_eff  = pop_i && !empty_o;
        base     = count_q - CNT_W'(pop_eff);
        push_eff = push_i && (base < CNT_W'(FETCH_DEPTH));
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_eff) begin
                for (int i = 0; i < FETCH_DEPTH - 1; i++) begin
                    slot_d[i] = slot_q[i + 1];
                end
            end
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                if (push_eff && (base == CNT_W'(i))) begin
                    slot_d[i] = '{pc: push_pc_i, inst: push_inst_i};
                end
            end
            count_d = base + CNT_W'(push_eff);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            for (int i = 0; i < FETCH_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, push policy and RUN/HALT FSM feeding a
// 2-entry buffer. Define FETCH_HALT_DETECT_EN to stop fetch on HALT_INST.
module instr_fetch_unit
    import legv8_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              halted
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              transfer;
    logic              push;
    logic              run;

    assign rom_addr   = pc_q;
    assign inst_valid = !fifo_empty;
    assign transfer   = inst_valid && inst_ready;

`ifdef FETCH_HALT_DETECT_EN
    fetch_state_e state_q, state_d;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else if (push && (rom_data == HALT_INST)) begin
            state_d = ST_HALT;
        end
    end

    assign run    = (state_q == ST_RUN);
    assign halted = (state_q == ST_HALT);
`else
    assign run    = 1'b1;
    assign halted = 1'b0;
`endif

    // A transfer frees a slot in the same edge, so a full buffer can still stream.
    assign push = run && !redirect_valid && (!fifo_full || transfer);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (push) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk_i       (clock),
        .rst_n_i     (reset_n),
        .push_i      (push),
        .push_pc_i   (pc_q),
        .push_inst_i (rom_data),
        .pop_i       (transfer),
        .flush_i     (redirect_valid),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_pc_o   (inst_pc),
        .head_inst_o (inst_out)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, all
// checked against a queue-based reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'hD600_03E0;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_DET = 1'b1;
`else
    localparam bit HALT_DET = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [31:0] inst_out;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;

    logic        halt_en;
    logic [15:0] halt_addr;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_qpc[$];
    logic [31:0] m_qinst[$];
    bit          m_halted;
    bit          seen9;

    always #5 clock = ~clock;

    assign rom_data = (halt_en && rom_addr == halt_addr) ? HALT_WORD
                                                         : 32'h1000_0000 + {16'h0, rom_addr};

    instr_fetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .halted         (halted)
    );

    function automatic logic [31:0] rom_model(input logic [15:0] a);
        return (halt_en && a == halt_addr) ? HALT_WORD : 32'h1000_0000 + {16'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 16'h0;
        m_qpc.delete();
        m_qinst.delete();
        m_halted = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_out", inst_out, 32'h0);
        chk("rst_pc", 32'(inst_pc), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    endtask

    task automatic check_model();
        chk("m_valid", 32'(inst_valid), 32'(m_qpc.size() != 0));
        chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("m_halted", 32'(halted), 32'(m_halted));
        if (m_qpc.size() != 0) begin
            chk("m_inst_pc", 32'(inst_pc), 32'(m_qpc[0]));
            chk("m_inst_out", inst_out, m_qinst[0]);
        end
    endtask

    task automatic model_edge(input bit xfer);
        logic [31:0] w;
        if (!reset_n) begin
            model_reset();
        end else if (redirect_valid) begin
            m_qpc.delete();
            m_qinst.delete();
            m_pc     = redirect_pc;
            m_halted = 1'b0;
        end else begin
            if (xfer) begin
                void'(m_qpc.pop_front());
                void'(m_qinst.pop_front());
            end
            if (!m_halted && m_qpc.size() < 2) begin
                w = rom_model(m_pc);
                m_qpc.push_back(m_pc);
                m_qinst.push_back(w);
                if (HALT_DET && w == HALT_WORD) m_halted = 1'b1;
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs checked there, model stepped at the rising edge.
    task automatic cycle();
        bit xfer;
        check_model();
        xfer = (m_qpc.size() != 0) && inst_ready;
        if (xfer && inst_pc == 16'd9 && inst_out == HALT_WORD) seen9 = 1'b1;
        @(posedge clock);
        model_edge(xfer);
        @(negedge clock);
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        inst_ready     = 1'b0;
        halt_en        = 1'b0;
        halt_addr      = 16'h0;
        seen9          = 1'b0;
        @(posedge clock);
        @(negedge clock);
        model_reset();
        check_reset_vals();
        cycle();

        // streaming from reset release
        reset_n    = 1'b1;
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("stream_pc", 32'(inst_pc), 32'(k));
            chk("stream_valid", 32'(inst_valid), 32'h1);
        end

        // back-pressure
        reset_n = 1'b0;
        cycle();
        check_reset_vals();
        reset_n    = 1'b1;
        inst_ready = 1'b0;
        repeat (7) cycle();
        chk("bp_rom_addr", 32'(rom_addr), 32'h2);
        chk("bp_head", 32'(inst_pc), 32'h0);
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_drain_pc", 32'(inst_pc), 32'(k));
            cycle();
        end

        // redirect with two entries buffered and a simultaneous transfer
        inst_ready = 1'b0;
        repeat (2) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        inst_ready     = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        chk("redir_flush", 32'(inst_valid), 32'h0);
        cycle();
        chk("redir_pc", 32'(inst_pc), 32'h40);
        chk("redir_valid", 32'(inst_valid), 32'h1);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        cycle();
        redirect_valid = 1'b0;
        cycle();
        chk("wrap_ffff", 32'(inst_pc), 32'hFFFF);
        cycle();
        chk("wrap_0000", 32'(inst_pc), 32'h0);

        // halt word at address 9
        halt_en        = 1'b1;
        halt_addr      = 16'd9;
        seen9          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0;
        cycle();
        redirect_valid = 1'b0;
        repeat (14) cycle();
        chk("halt_seen9", 32'(seen9), 32'h1);
        chk("halt_flag", 32'(halted), 32'(HALT_DET));
        chk("halt_rom_addr", 32'(rom_addr), HALT_DET ? 32'd10 : 32'd14);
        chk("halt_drained", 32'(inst_valid), 32'(!HALT_DET));
        redirect_valid = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        chk("halt_clear", 32'(halted), 32'h0);

        // reset while full (and halted when detection is built in)
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd8;
        cycle();
        redirect_valid = 1'b0;
        repeat (3) cycle();
        chk("full_halted", 32'(halted), 32'(HALT_DET));
        reset_n = 1'b0;
        cycle();
        check_reset_vals();
        reset_n = 1'b1;
        cycle();
        chk("restart_pc", 32'(inst_pc), 32'h0);
        chk("restart_valid", 32'(inst_valid), 32'h1);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 16'($urandom_range(0, 65535));
                1:       redirect_pc = 16'hFFFE;
                default: redirect_pc = 16'($urandom_range(0, 24));
            endcase
            if ($urandom_range(0, 29) == 0) halt_addr = 16'($urandom_range(0, 24));
            reset_n = ($urandom_range(0, 59) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
